pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 pipeline_flush  input  pipeline_flush_t  fields ex, eret, tlb_op; any set = architectural redirect.
REQ-004 flush_target  input  virt_t  redirect PC for pipeline_flush (exception vector, EPC, refetch PC).
REQ-005 bpu_flush  input  1  one-cycle pulse: EX-stage misprediction detected.
REQ-006 bpu_correct_target  input  virt_t  corrected PC, valid with bpu_flush.
REQ-007 bpu_predict_bus  input  predict_result_t  registered prediction (valid, br_op, br_taken, target) for the request accepted last cycle.
REQ-008 fetch_ready  input  1  instruction side accepts the current request.
REQ-009 if_pc  output  virt_t  current fetch PC.
REQ-010 if_valid  output  1  fetch request valid.
REQ-011 correct_finish  output  1  one-cycle pulse: first request at the corrected target accepted.
REQ-012 RESET_PC  parameter  32'hBFC0_0000  PC loaded on reset.

Function
REQ-013 Request accepted ("fire") = if_valid && fetch_ready; if_pc SHALL hold while if_valid && !fetch_ready.
REQ-014 FSM states SEQ, DS_PEND, CORR; reset state SEQ.
REQ-015 Next-PC priority: pipeline_flush > bpu_flush > pending prediction > sequential if_pc+4.
REQ-016 Sequential increment SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-017 Any pipeline_flush field set: next if_pc = flush_target, state -> SEQ, pending target cleared, if_valid low that cycle.
REQ-018 bpu_flush (no pipeline_flush): next if_pc = bpu_correct_target, state -> CORR, if_valid low that cycle, regardless of fetch_ready.
REQ-019 CORR: first fire pulses correct_finish one cycle and moves to SEQ; pipeline_flush in CORR -> SEQ without pulse.
REQ-020 SEQ with bpu_predict_bus.valid && br_op && br_taken: current request is the delay slot; target latched into pending register, state -> DS_PEND.
REQ-021 Delay slot fired in the prediction cycle: next if_pc = target directly, state stays SEQ, no pending latch.
REQ-022 DS_PEND: if_pc holds delay slot until fire; after fire next if_pc = pending target, state -> SEQ.
REQ-023 Predictions arriving in DS_PEND or CORR SHALL be ignored.
REQ-024 Prediction in same cycle as any flush SHALL be ignored.
REQ-025 Misaligned targets SHALL be issued unmodified; fault detection is downstream.
REQ-026 if_valid high every cycle outside reset and flush cycles.

Reset
REQ-027 On reset assertion, immediately: if_pc = RESET_PC, if_valid = 0, correct_finish = 0, state SEQ, pending target 0.
REQ-028 if_valid rises on first clock edge after reset deassertion; reset mid-DS_PEND/CORR discards pending state.

Structure
REQ-029 virt_t, pipeline_flush_t, predict_result_t and state encoding SHALL come from the shared cpu package header; RESET_PC default defined there.
REQ-030 Single flat module; no sub-module.

Verification
REQ-031 Reset release, fetch_ready=1 -> if_pc BFC00000, BFC00004, BFC00008 on consecutive cycles.
REQ-032 Predict taken target 80001000 for branch at 80000000, fetch_ready=1 at delay slot -> if_pc 80000004 then 80001000.
REQ-033 Same, fetch_ready=0 for 3 cycles at delay slot -> if_pc holds 80000004 (DS_PEND), then 80001000 after fire.
REQ-034 bpu_flush target 80002000, fetch_ready stalls 2 cycles -> if_valid low one cycle, correct_finish single pulse on fire at 80002000.
REQ-035 pipeline_flush.ex with bpu_flush and taken prediction together, flush_target 80000180 -> next if_pc 80000180, no correct_finish.
REQ-036 if_pc FFFFFFFC fires -> next if_pc 00000000.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// rtl/pc_gen_pkg.sv - shared cpu types, state encoding and reset vector for the fetch PC generator
package pc_gen_pkg;

  typedef logic [31:0] virt_t;

  typedef struct packed {
    logic ex;
    logic eret;
    logic tlb_op;
  } pipeline_flush_t;

  typedef struct packed {
    logic  valid;
    logic  br_op;
    logic  br_taken;
    virt_t target;
  } predict_result_t;

  typedef enum logic [1:0] {
    ST_SEQ     = 2'd0,
    ST_DS_PEND = 2'd1,
    ST_CORR    = 2'd2
  } pc_state_t;

  localparam virt_t RESET_PC_DEFAULT = 32'hBFC0_0000;

  function automatic logic flush_any(input pipeline_flush_t f);
    return f.ex | f.eret | f.tlb_op;
  endfunction

  function automatic logic pred_taken(input predict_result_t p);
    return p.valid & p.br_op & p.br_taken;
  endfunction

endpackage

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator with flush redirects, branch delay slot and misprediction correction
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter virt_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  pipeline_flush_t pipeline_flush,
  input  virt_t           flush_target,
  input  logic            bpu_flush,
  input  virt_t           bpu_correct_target,
  input  predict_result_t bpu_predict_bus,
  input  logic            fetch_ready,
  output virt_t           if_pc,
  output logic            if_valid,
  output logic            correct_finish
);

  pc_state_t state;
  virt_t     pending_target;
  logic      fire;
  virt_t     seq_pc;

  assign fire   = if_valid & fetch_ready;
  assign seq_pc = if_pc + 32'd4;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_pc          <= RESET_PC;
      if_valid       <= 1'b0;
      correct_finish <= 1'b0;
      state          <= ST_SEQ;
      pending_target <= '0;
    end else begin
      correct_finish <= 1'b0;
      if (flush_any(pipeline_flush)) begin
        if_pc          <= flush_target;
        if_valid       <= 1'b0;
        state          <= ST_SEQ;
        pending_target <= '0;
      end else if (bpu_flush) begin
        if_pc    <= bpu_correct_target;
        if_valid <= 1'b0;
        state    <= ST_CORR;
      end else begin
        if_valid <= 1'b1;
        case (state)
          ST_SEQ: begin
            // A taken prediction refers to the branch just accepted, so if_pc is its delay slot.
            if (pred_taken(bpu_predict_bus)) begin
              if (fire) begin
                if_pc <= bpu_predict_bus.target;
              end else begin
                pending_target <= bpu_predict_bus.target;
                state          <= ST_DS_PEND;
              end
            end else if (fire) begin
              if_pc <= seq_pc;
            end
          end
          ST_DS_PEND: begin
            if (fire) begin
              if_pc <= pending_target;
              state <= ST_SEQ;
            end
          end
          ST_CORR: begin
            if (fire) begin
              if_pc          <= seq_pc;
              correct_finish <= 1'b1;
              state          <= ST_SEQ;
            end
          end
          default: state <= ST_SEQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - randomized and directed self-checking bench for pc_gen
module tb_pc_gen;
  import pc_gen_pkg::*;

  logic            clk;
  logic            reset;
  pipeline_flush_t pipeline_flush;
  virt_t           flush_target;
  logic            bpu_flush;
  virt_t           bpu_correct_target;
  predict_result_t bpu_predict_bus;
  logic            fetch_ready;
  virt_t           if_pc;
  logic            if_valid;
  logic            correct_finish;

  pc_gen dut (
    .clk                (clk),
    .reset              (reset),
    .pipeline_flush     (pipeline_flush),
    .flush_target       (flush_target),
    .bpu_flush          (bpu_flush),
    .bpu_correct_target (bpu_correct_target),
    .bpu_predict_bus    (bpu_predict_bus),
    .fetch_ready        (fetch_ready),
    .if_pc              (if_pc),
    .if_valid           (if_valid),
    .correct_finish     (correct_finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference: the fetch stream as an expected PC, a queue holding at most one
  // redirect owed after the delay slot, and a flag for an outstanding correction.
  virt_t m_pc;
  logic  m_valid;
  logic  m_cf;
  logic  m_corr;
  virt_t m_owed[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'hBFC0_0000;
    m_valid = 1'b0;
    m_cf    = 1'b0;
    m_corr  = 1'b0;
    m_owed.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_pc", if_pc, 32'hBFC0_0000);
    chk("rst_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_cf", {31'b0, correct_finish}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // Called at a falling edge: checks the current outputs, applies one cycle of inputs.
  task automatic cyc(input logic [2:0] fl, input virt_t ft, input logic bf, input virt_t bt,
                     input logic [2:0] pr, input virt_t pt, input logic rdy);
    logic accepted;
    chk("if_pc", if_pc, m_pc);
    chk("if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("correct_finish", {31'b0, correct_finish}, {31'b0, m_cf});
    pipeline_flush     = fl;
    flush_target       = ft;
    bpu_flush          = bf;
    bpu_correct_target = bt;
    bpu_predict_bus    = {pr, pt};
    fetch_ready        = rdy;

    accepted = m_valid && rdy;
    m_cf     = 1'b0;
    if (fl != 3'b000) begin
      m_pc    = ft;
      m_valid = 1'b0;
      m_corr  = 1'b0;
      m_owed.delete();
    end else if (bf) begin
      m_pc    = bt;
      m_valid = 1'b0;
      m_corr  = 1'b1;
      m_owed.delete();
    end else begin
      if (m_corr) begin
        if (accepted) begin
          m_cf   = 1'b1;
          m_corr = 1'b0;
          m_pc   = m_pc + 32'd4;
        end
      end else if (m_owed.size() != 0) begin
        if (accepted) m_pc = m_owed.pop_front();
      end else if (pr == 3'b111) begin
        if (accepted) m_pc = pt;
        else m_owed.push_back(pt);
      end else if (accepted) begin
        m_pc = m_pc + 32'd4;
      end
      m_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    cyc(3'b000, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, rdy);
  endtask

  task automatic go_to(input virt_t pc);
    cyc(3'b100, pc, 1'b0, 32'h0, 3'b000, 32'h0, 1'b1);
    idle(1'b1);
  endtask

  initial begin
    reset              = 1'b1;
    pipeline_flush     = '0;
    flush_target       = '0;
    bpu_flush          = 1'b0;
    bpu_correct_target = '0;
    bpu_predict_bus    = '0;
    fetch_ready        = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("por_pc", if_pc, 32'hBFC0_0000);
    chk("por_valid", {31'b0, if_valid}, 32'd0);
    reset = 1'b0;

    // Sequential fetch out of reset
    idle(1'b1);
    chk("seq0", if_pc, 32'hBFC0_0000);
    chk("seq0_valid", {31'b0, if_valid}, 32'd1);
    idle(1'b1);
    chk("seq1", if_pc, 32'hBFC0_0004);
    idle(1'b1);
    chk("seq2", if_pc, 32'hBFC0_0008);

    // Taken prediction, delay slot accepted immediately
    go_to(32'h8000_0000);
    idle(1'b1);
    chk("ds_fire", if_pc, 32'h8000_0004);
    cyc(3'b000, 32'h0, 1'b0, 32'h0, 3'b111, 32'h8000_1000, 1'b1);
    chk("tgt_fire", if_pc, 32'h8000_1000);

    // Taken prediction, delay slot stalled three cycles
    go_to(32'h8000_0000);
    idle(1'b1);
    cyc(3'b000, 32'h0, 1'b0, 32'h0, 3'b111, 32'h8000_1000, 1'b0);
    chk("ds_hold0", if_pc, 32'h8000_0004);
    cyc(3'b000, 32'h0, 1'b0, 32'h0, 3'b111, 32'h9000_0000, 1'b0);
    idle(1'b0);
    chk("ds_hold2", if_pc, 32'h8000_0004);
    idle(1'b1);
    chk("ds_pend_tgt", if_pc, 32'h8000_1000);

    // Misprediction correction with a two-cycle stall
    cyc(3'b000, 32'h0, 1'b1, 32'h8000_2000, 3'b000, 32'h0, 1'b1);
    chk("corr_pc", if_pc, 32'h8000_2000);
    chk("corr_valid_low", {31'b0, if_valid}, 32'd0);
    idle(1'b0);
    idle(1'b0);
    chk("corr_no_cf", {31'b0, correct_finish}, 32'd0);
    idle(1'b1);
    chk("corr_cf", {31'b0, correct_finish}, 32'd1);
    idle(1'b1);
    chk("corr_cf_once", {31'b0, correct_finish}, 32'd0);

    // Architectural flush beats misprediction and prediction
    cyc(3'b100, 32'h8000_0180, 1'b1, 32'h8000_2000, 3'b111, 32'h8000_1000, 1'b1);
    chk("flush_pc", if_pc, 32'h8000_0180);
    chk("flush_cf", {31'b0, correct_finish}, 32'd0);
    idle(1'b1);
    idle(1'b1);
    chk("flush_seq", if_pc, 32'h8000_0184);

    // 32-bit wrap
    go_to(32'hFFFF_FFFC);
    idle(1'b1);
    chk("wrap", if_pc, 32'h0000_0000);

    // Reset in the middle of a pending delay slot
    go_to(32'h8000_0000);
    idle(1'b1);
    cyc(3'b000, 32'h0, 1'b0, 32'h0, 3'b111, 32'h8000_1000, 1'b0);
    do_reset();
    idle(1'b1);
    idle(1'b1);
    chk("rst_discard", if_pc, 32'hBFC0_0004);

    for (int i = 0; i < 3000; i++) begin
      logic [2:0] fl;
      logic       bf;
      logic [2:0] pr;
      if ($urandom_range(0, 299) == 0) do_reset();
      fl = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      bf = ($urandom_range(0, 11) == 0);
      pr = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom_range(0, 7));
      cyc(fl, $urandom, bf, $urandom, pr, $urandom, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
